// File: rtl/lsu_access_unit.sv
// Load/store access unit: turns decoder MREN/MWEN micro-commands into one
// valid/ready data-memory transaction. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mren,
    input  logic [1:0]        mwen,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                we_q, we_d;
    logic                uns_q, uns_d;
    logic [3:0]          wmask_q, wmask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [1:0]          req_size_c;
    logic                req_conflict_c, req_noop_c, req_fault_c;
    logic [3:0]          lane_mask_c;
    logic [DATA_W-1:0]   lane_data_c;
    logic [7:0]          ld_byte_c;
    logic [15:0]         ld_half_c;
    logic [DATA_W-1:0]   load_data_c;

    // Request decode and store lane placement from the live execute-stage inputs
    always_comb begin
        req_size_c     = mren | mwen;
        req_conflict_c = (mren != 2'b00) && (mwen != 2'b00);
        req_noop_c     = (mren == 2'b00) && (mwen == 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        req_fault_c    = ((req_size_c == SZ_H) && addr[0]) ||
                         ((req_size_c == 2'b11) && (addr[1:0] != 2'b00));
`else
        req_fault_c    = 1'b0;
`endif
        case (req_size_c)
            SZ_B: begin
                lane_mask_c = 4'(4'b0001 << addr[1:0]);
                lane_data_c = {4{wdata[7:0]}};
            end
            SZ_H: begin
                lane_mask_c = 4'(4'b0011 << {addr[1], 1'b0});
                lane_data_c = {2{wdata[15:0]}};
            end
            default: begin
                lane_mask_c = 4'b1111;
                lane_data_c = wdata;
            end
        endcase
    end

    // Load extraction from the raw word using the captured offset and size
    always_comb begin
        ld_byte_c = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half_c = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    load_data_c = uns_q ? {24'b0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
            SZ_H:    load_data_c = uns_q ? {16'b0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
            default: load_data_c = mem_rdata;
        endcase
        if (we_q) begin
            load_data_c = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_d  = addr;
                    size_d  = req_size_c;
                    uns_d   = load_unsigned;
                    we_d    = 1'b0;
                    wmask_d = 4'b0000;
                    wdata_d = '0;
                    rdata_d = '0;
                    err_d   = req_conflict_c || req_fault_c;
                    if (req_conflict_c || req_noop_c || req_fault_c) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                        if (mwen != 2'b00) begin
                            we_d    = 1'b1;
                            wmask_d = lane_mask_c;
                            wdata_d = lane_data_c;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        rdata_d = load_data_c;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = load_data_c;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wmask_q <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign mem_valid = (state_q == ST_REQ);
    assign out_valid = (state_q == ST_RESP);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wmask = wmask_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu_access_unit.sv
// Directed bench for lsu_access_unit; inputs change and outputs are sampled on the falling edge.
module tb_lsu_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  mren, mwen;
    logic        load_unsigned;
    logic [31:0] addr, wdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] rdata;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .mren(mren), .mwen(mwen), .load_unsigned(load_unsigned),
        .addr(addr), .wdata(wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .rdata(rdata), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns on the falling edge of cycle 1.
    task automatic issue(input logic [1:0] r, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        chk1("in_ready_before_issue", in_ready, 1'b1);
        in_valid = 1'b1; mren = r; mwen = w; load_unsigned = u; addr = a; wdata = d;
        @(negedge clk);
        in_valid = 1'b0; mren = 2'b00; mwen = 2'b00; load_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0;
    endtask

    // Zero-wait memory handshake: ready and response together in the REQ cycle.
    task automatic mem_zero_wait(input logic [31:0] raw);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = raw;
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
        chk1({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk1({tag, "_err"}, err, exp_err);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1({tag, "_out_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mren = 2'b00; mwen = 2'b00; load_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'h0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Store byte at offset 3
        issue(2'b00, 2'b01, 1'b0, 32'h8000_0003, 32'h1234_56AB);
        chk1("sb_mem_valid", mem_valid, 1'b1);
        chk1("sb_in_ready", in_ready, 1'b0);
        chk("sb_mem_addr", mem_addr, 32'h8000_0000);
        chk("sb_wmask", 32'(mem_wmask), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk1("sb_we", mem_we, 1'b1);
        mem_zero_wait(32'h0);
        expect_resp("sb", 32'h0, 1'b0);

        // Store half at offset 2
        issue(2'b00, 2'b10, 1'b0, 32'h0000_0102, 32'h1234_ABCD);
        chk("sh_wmask", 32'(mem_wmask), 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_mem_addr", mem_addr, 32'h0000_0100);
        mem_zero_wait(32'h0);
        expect_resp("sh", 32'h0, 1'b0);

        // Store word
        issue(2'b00, 2'b11, 1'b0, 32'h0000_0200, 32'hCAFE_F00D);
        chk("sw_wmask", 32'(mem_wmask), 32'hF);
        chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_zero_wait(32'h0);
        expect_resp("sw", 32'h0, 1'b0);

        // Load byte signed / unsigned at offset 2
        issue(2'b01, 2'b00, 1'b0, 32'h0000_1002, 32'h0);
        chk1("lb_mem_we", mem_we, 1'b0);
        chk("lb_wmask", 32'(mem_wmask), 32'h0);
        chk("lb_mem_addr", mem_addr, 32'h0000_1000);
        mem_zero_wait(32'h80FF_7F01);
        expect_resp("lb_s", 32'hFFFF_FFFF, 1'b0);
        issue(2'b01, 2'b00, 1'b1, 32'h0000_1002, 32'h0);
        mem_zero_wait(32'h80FF_7F01);
        expect_resp("lb_u", 32'h0000_00FF, 1'b0);

        // Load byte offset 1, sign bit clear
        issue(2'b01, 2'b00, 1'b0, 32'h0000_1001, 32'h0);
        mem_zero_wait(32'h80FF_7F01);
        expect_resp("lb_o1", 32'h0000_007F, 1'b0);

        // Load half unsigned at offset 0
        issue(2'b10, 2'b00, 1'b1, 32'h0000_1100, 32'h0);
        mem_zero_wait(32'h1234_F00D);
        expect_resp("lhu", 32'h0000_F00D, 1'b0);

        // Load half with memory backpressure and writeback stall
        issue(2'b10, 2'b00, 1'b0, 32'h0000_2002, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk1("lh_bp_mem_valid", mem_valid, 1'b1);
            chk("lh_bp_mem_addr", mem_addr, 32'h0000_2000);
            @(negedge clk);
        end
        chk1("lh_bp_mem_valid_last", mem_valid, 1'b1);
        chk("lh_bp_mem_addr_last", mem_addr, 32'h0000_2000);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk1("lh_wait_mem_valid", mem_valid, 1'b0);
        chk1("lh_wait_out_valid", out_valid, 1'b0);
        @(negedge clk);
        chk1("lh_wait2_out_valid", out_valid, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h0;
            chk1("lh_hold_out_valid", out_valid, 1'b1);
            chk("lh_hold_rdata", rdata, 32'hFFFF_8001);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        expect_resp("lh", 32'hFFFF_8001, 1'b0);
        chk1("lh_in_ready_after", in_ready, 1'b1);

        // Conflicting enables
        issue(2'b11, 2'b11, 1'b0, 32'h0000_3000, 32'h0);
        chk1("conf_mem_valid", mem_valid, 1'b0);
        expect_resp("conf", 32'h0, 1'b1);

        // No-op
        issue(2'b00, 2'b00, 1'b0, 32'h0000_3000, 32'h0);
        chk1("noop_mem_valid", mem_valid, 1'b0);
        expect_resp("noop", 32'h0, 1'b0);

        // Misaligned word load
        issue(2'b11, 2'b00, 1'b0, 32'h0000_4001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk1("mis_mem_valid", mem_valid, 1'b0);
        expect_resp("mis", 32'h0, 1'b1);
`else
        chk1("mis_mem_valid", mem_valid, 1'b1);
        chk("mis_mem_addr", mem_addr, 32'h0000_4000);
        mem_zero_wait(32'hDEAD_BEEF);
        expect_resp("mis", 32'hDEAD_BEEF, 1'b0);
`endif

        // Reset while the request is on the memory port
        issue(2'b11, 2'b00, 1'b0, 32'h0000_5000, 32'h0);
        chk1("rreq_mem_valid", mem_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rreq_mem_valid_drop", mem_valid, 1'b0);
        chk("rreq_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in WAIT, then a stray response in IDLE
        issue(2'b11, 2'b00, 1'b0, 32'h0000_6000, 32'h0);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk1("rwait_mem_valid", mem_valid, 1'b0);
        chk1("rwait_in_ready", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("rwait_mem_valid_rst", mem_valid, 1'b0);
        chk1("rwait_out_valid_rst", out_valid, 1'b0);
        chk1("rwait_in_ready_rst", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk1("rwait_stray_out_valid", out_valid, 1'b0);
        chk1("rwait_stray_in_ready", in_ready, 1'b1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk1("rwait_stray_out_valid2", out_valid, 1'b0);
        chk("rwait_stray_rdata", rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
